// File: rtl/mux_pkg.sv
// Shared types and helpers for the scanning multiplexer.
package mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Width of a channel index; never below one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Counts enabled cycles modulo DWELL; wrap marks the last cycle of a dwell.
module dwell_counter #(
    parameter int unsigned DWELL = 16
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt;

    assign wrap = en && !clr && (cnt == LAST);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux_scan.sv
// N-channel registered multiplexer with manual selection or round-robin scan.
module mux_scan
    import mux_pkg::*;
#(
    parameter  int unsigned WIDTH    = 8,
    parameter  int unsigned CHANNELS = 4,
    parameter  int unsigned DWELL    = 16,
    localparam int unsigned SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic [CHANNELS*WIDTH-1:0] Data_in,
    input  logic [SEL_W-1:0]          Select,
    input  logic                      Mode,
    input  logic                      Enable,
    output logic [WIDTH-1:0]          Y,
    output logic                      Y_valid,
    output logic [SEL_W-1:0]          Ch_out,
    output logic                      Switch_pulse,
    output logic                      Sel_err
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ch_q, ch_d, next_ch;
    logic [WIDTH-1:0]   y_d, cur_data;
    logic               y_valid_d, switch_d, sel_err_d;
    logic               cnt_en, cnt_clr, wrap;
    logic               sel_ok;

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .wrap  (wrap)
    );

    // Data slice of the channel currently held in the channel register.
    always_comb begin
        cur_data = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (ch_q == SEL_W'(c)) begin
                cur_data = Data_in[c*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_ok  = 32'(Select) < CHANNELS;
    assign next_ch = (ch_q == SEL_W'(CHANNELS - 1)) ? '0 : ch_q + SEL_W'(1);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        y_d       = Y;
        y_valid_d = 1'b0;
        switch_d  = 1'b0;
        sel_err_d = 1'b0;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;

        if (!Enable) begin
            state_d = ST_IDLE;
        end else begin
            y_d       = cur_data;
            y_valid_d = 1'b1;
            if (Mode == MODE_SCAN) begin
                state_d = ST_SCAN;
                cnt_en  = 1'b1;
                // The edge that leaves manual mode never advances the channel.
                if (wrap && (state_q != ST_MANUAL)) begin
                    ch_d     = next_ch;
                    switch_d = 1'b1;
                end
            end else begin
                state_d = ST_MANUAL;
                cnt_clr = 1'b1;
                if (!sel_ok) begin
                    sel_err_d = 1'b1;
                end else if (Select != ch_q) begin
                    ch_d     = Select;
                    switch_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Y            <= '0;
            Y_valid      <= 1'b0;
            ch_q         <= '0;
            Switch_pulse <= 1'b0;
            Sel_err      <= 1'b0;
        end else begin
            Y            <= y_d;
            Y_valid      <= y_valid_d;
            ch_q         <= ch_d;
            Switch_pulse <= switch_d;
            Sel_err      <= sel_err_d;
        end
    end

    assign Ch_out = ch_q;

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: directed vector table, illegal-select sequence, random scoreboard run.
module tb_mux_scan;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Four-channel instance, DWELL=3
    logic        rst_n, en, mode;
    logic [1:0]  sel;
    logic [31:0] din;
    logic [7:0]  y;
    logic        yv, sw, err;
    logic [1:0]  ch;

    mux_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) dut4 (
        .Clk(Clk), .Rst_n(rst_n), .Data_in(din), .Select(sel), .Mode(mode),
        .Enable(en), .Y(y), .Y_valid(yv), .Ch_out(ch), .Switch_pulse(sw), .Sel_err(err)
    );

    // Three-channel instance for the illegal select case
    logic        d3_rst_n, d3_en, d3_mode;
    logic [1:0]  d3_sel;
    logic [23:0] d3_din;
    logic [7:0]  d3_y;
    logic        d3_yv, d3_sw, d3_err;
    logic [1:0]  d3_ch;

    mux_scan #(.WIDTH(8), .CHANNELS(3), .DWELL(3)) dut3 (
        .Clk(Clk), .Rst_n(d3_rst_n), .Data_in(d3_din), .Select(d3_sel), .Mode(d3_mode),
        .Enable(d3_en), .Y(d3_y), .Y_valid(d3_yv), .Ch_out(d3_ch), .Switch_pulse(d3_sw),
        .Sel_err(d3_err)
    );

    typedef struct {
        logic       r, e, m;
        logic [1:0] s;
        logic [7:0] y;
        logic       v;
        logic [1:0] c;
        logic       p;
    } vec_t;

    typedef struct {
        logic [7:0] y;
        logic       v;
        logic [1:0] c;
        logic       p;
        logic       e;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int   m_ch, m_cnt;
    logic [7:0] m_y;

    function automatic vec_t mk(int r, int e, int m, int s, int yy, int v, int c, int p);
        vec_t t;
        t.r = 1'(r); t.e = 1'(e); t.m = 1'(m); t.s = 2'(s);
        t.y = 8'(yy); t.v = 1'(v); t.c = 2'(c); t.p = 1'(p);
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance one edge and compare the four-channel instance against the queue head.
    task automatic tick(input string tag);
        exp_t e;
        @(posedge Clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".y"},   32'(y),   32'(e.y));
            check({tag, ".vld"}, 32'(yv),  32'(e.v));
            check({tag, ".ch"},  32'(ch),  32'(e.c));
            check({tag, ".sw"},  32'(sw),  32'(e.p));
            check({tag, ".err"}, 32'(err), 32'(e.e));
        end
    endtask

    // Behavioural reference for the four-channel, DWELL=3 instance.
    task automatic model_push();
        exp_t e;
        e.p = 1'b0;
        e.e = 1'b0;
        if (!rst_n) begin
            m_ch = 0; m_cnt = 0; m_y = 8'h00;
            e.v = 1'b0;
        end else if (!en) begin
            e.v = 1'b0;
        end else begin
            m_y = din[m_ch*8 +: 8];
            e.v = 1'b1;
            if (!mode) begin
                m_cnt = 0;
                if (int'(sel) != m_ch) begin
                    m_ch = int'(sel);
                    e.p  = 1'b1;
                end
            end else begin
                m_cnt++;
                if (m_cnt == 3) begin
                    m_cnt = 0;
                    m_ch  = (m_ch + 1) % 4;
                    e.p   = 1'b1;
                end
            end
        end
        e.y = m_y;
        e.c = 2'(m_ch);
        sb_q.push_back(e);
    endtask

    task automatic tick3(input string tag, input logic [7:0] ey, input logic [1:0] ec,
                         input logic ep, input logic ee);
        @(posedge Clk);
        #1;
        check({tag, ".y"},   32'(d3_y),   32'(ey));
        check({tag, ".vld"}, 32'(d3_yv),  32'd1);
        check({tag, ".ch"},  32'(d3_ch),  32'(ec));
        check({tag, ".sw"},  32'(d3_sw),  32'(ep));
        check({tag, ".err"}, 32'(d3_err), 32'(ee));
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel = 2'd3; din = 32'hDDCCBBAA;
        d3_rst_n = 1'b0; d3_en = 1'b1; d3_mode = 1'b0; d3_sel = 2'd0; d3_din = 24'hCCBBAA;

        // r e m s  y    v c p
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,1,3, 'h00,0,0,0));
        tbl.push_back(mk(1,1,0,0, 'hAA,1,0,0));
        tbl.push_back(mk(1,1,0,2, 'hAA,1,2,1));
        tbl.push_back(mk(1,1,0,2, 'hCC,1,2,0));
        tbl.push_back(mk(1,1,0,0, 'hCC,1,0,1));
        tbl.push_back(mk(1,1,0,0, 'hAA,1,0,0));
        tbl.push_back(mk(1,1,1,2, 'hAA,1,0,0));
        tbl.push_back(mk(1,1,1,2, 'hAA,1,0,0));
        tbl.push_back(mk(1,1,1,2, 'hAA,1,1,1));
        tbl.push_back(mk(1,1,1,2, 'hBB,1,1,0));
        tbl.push_back(mk(1,1,1,2, 'hBB,1,1,0));
        tbl.push_back(mk(1,1,1,2, 'hBB,1,2,1));
        tbl.push_back(mk(1,1,1,2, 'hCC,1,2,0));
        tbl.push_back(mk(1,0,1,0, 'hCC,0,2,0));
        tbl.push_back(mk(1,0,0,1, 'hCC,0,2,0));
        tbl.push_back(mk(1,0,1,3, 'hCC,0,2,0));
        tbl.push_back(mk(1,0,0,0, 'hCC,0,2,0));
        tbl.push_back(mk(1,0,1,1, 'hCC,0,2,0));
        tbl.push_back(mk(1,1,1,0, 'hCC,1,2,0));
        tbl.push_back(mk(1,1,1,0, 'hCC,1,3,1));
        tbl.push_back(mk(1,1,1,0, 'hDD,1,3,0));
        tbl.push_back(mk(1,1,1,0, 'hDD,1,3,0));
        tbl.push_back(mk(1,1,1,0, 'hDD,1,0,1));
        tbl.push_back(mk(1,1,1,0, 'hAA,1,0,0));
        tbl.push_back(mk(1,1,1,0, 'hAA,1,0,0));
        tbl.push_back(mk(1,1,0,1, 'hAA,1,1,1));
        tbl.push_back(mk(1,1,0,1, 'hBB,1,1,0));
        tbl.push_back(mk(1,1,0,3, 'hBB,1,3,1));
        tbl.push_back(mk(1,1,1,3, 'hDD,1,3,0));
        tbl.push_back(mk(1,1,1,3, 'hDD,1,3,0));
        tbl.push_back(mk(0,1,1,3, 'h00,0,0,0));
        tbl.push_back(mk(1,1,1,3, 'hAA,1,0,0));
        tbl.push_back(mk(1,1,1,3, 'hAA,1,0,0));
        tbl.push_back(mk(1,1,1,3, 'hAA,1,1,1));
        tbl.push_back(mk(1,1,1,3, 'hBB,1,1,0));

        foreach (tbl[i]) begin
            rst_n = tbl[i].r; en = tbl[i].e; mode = tbl[i].m; sel = tbl[i].s;
            e.y = tbl[i].y; e.v = tbl[i].v; e.c = tbl[i].c; e.p = tbl[i].p; e.e = 1'b0;
            sb_q.push_back(e);
            tick($sformatf("row%0d", i));
        end

        // Illegal select on the three-channel instance
        d3_rst_n = 1'b1; d3_sel = 2'd1;
        tick3("n3a", 8'hAA, 2'd1, 1'b1, 1'b0);
        tick3("n3b", 8'hBB, 2'd1, 1'b0, 1'b0);
        d3_sel = 2'd3;
        tick3("n3c", 8'hBB, 2'd1, 1'b0, 1'b1);
        d3_sel = 2'd1;
        tick3("n3d", 8'hBB, 2'd1, 1'b0, 1'b0);
        d3_sel = 2'd2;
        tick3("n3e", 8'hBB, 2'd2, 1'b1, 1'b0);
        tick3("n3f", 8'hCC, 2'd2, 1'b0, 1'b0);

        // Random traffic against the reference model
        rst_n = 1'b0; en = 1'b1; mode = 1'b0; sel = 2'd0; din = $urandom;
        model_push();
        tick("rnd_rst");
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            en    = ($urandom_range(0, 5) != 0);
            mode  = ($urandom_range(0, 3) != 0);
            sel   = 2'($urandom_range(0, 3));
            din   = $urandom;
            model_push();
            tick($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised N-channel, W-bit registered multiplexer that replaces the 2:1 combinational `Mux` in the studie datapath. Channel selection comes either from an external `Select` (manual mode) or from an internal round-robin scanner that dwells a fixed number of cycles on each channel (scan mode). The output is registered, qualified by a valid flag, and the block reports which channel drives it.

## Interface
- `WIDTH`, 8: data bits per channel.
- `CHANNELS`, 4: number of input channels (≥2).
- `DWELL`, 16: cycles spent on each channel in scan mode (≥1).
- `SEL_W`, derived: `$clog2(CHANNELS)`; not overridden.

- `Clk`  in  1  single clock; all logic on rising edge.
- `Rst_n`  in  1  synchronous, active-low reset.
- `Data_in`  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- `Select`  in  SEL_W  manual-mode channel request.
- `Mode`  in  1  0 = manual, 1 = scan.
- `Enable`  in  1  1 = run; 0 = freeze.
- `Y`  out  WIDTH  registered selected data.
- `Y_valid`  out  1  Y holds data sampled while enabled.
- `Ch_out`  out  SEL_W  channel register (channel feeding Y next edge).
- `Switch_pulse`  out  1  one-cycle pulse when Ch_out changes.
- `Sel_err`  out  1  one-cycle pulse: manual Select ≥ CHANNELS.

## Operation
- Internal state: channel register `ch`, dwell counter `cnt` (0..DWELL-1), FSM {IDLE, MANUAL, SCAN}.
- Reset (Rst_n=0 at an edge): Y=0, Y_valid=0, Ch_out=0, Switch_pulse=0, Sel_err=0, cnt=0, state IDLE. Reset mid-scan discards position; restart at channel 0.
- IDLE: entered when Enable=0 from any state. Y, ch and cnt hold; Y_valid=0 and both pulses 0.
- From IDLE with Enable=1: Mode=0 → MANUAL, Mode=1 → SCAN. In MANUAL/SCAN, Mode toggle switches state on the same edge.
- Every enabled edge: Y ← Data_in slice for current `ch`; Y_valid ← 1.
- MANUAL: Select < CHANNELS and ≠ ch → ch ← Select, Switch_pulse=1. Select ≥ CHANNELS → ch holds, Sel_err=1 (possible only when CHANNELS is not a power of 2). cnt held at 0.
- SCAN: cnt increments each enabled edge; at cnt=DWELL-1, cnt ← 0 and ch ← ch+1, wrapping CHANNELS-1 → 0, Switch_pulse=1. Select ignored.
- DWELL=1: ch advances every enabled edge.
- MANUAL→SCAN: scan starts from current ch with cnt=0; no switch that edge.
- SCAN→MANUAL: cnt cleared; Select applied from that edge on.
- Enable low mid-dwell: cnt frozen; resumes from frozen value.

## Timing
- Data_in → Y: 1 cycle.
- Select change → Ch_out: 1 cycle; → Y reflecting new channel: 2 cycles.
- Enable rise → Y_valid rise: 1 cycle. Enable fall → Y_valid low the next edge.
- Switch_pulse and Sel_err are registered, aligned with the Ch_out update edge, and last exactly one cycle.
- Scan period: each channel drives Y for exactly DWELL consecutive enabled cycles; full rotation takes CHANNELS*DWELL cycles.

## Structure
- Package `mux_pkg`: FSM state enum, Mode encodings (MODE_MANUAL=0, MODE_SCAN=1), and the SEL_W helper function.
- Sub-module `dwell_counter` (params DWELL; ports Clk, Rst_n, en, clr, wrap): instantiated once, shared by SCAN timing. All other logic stays in `mux_scan`.

## Test plan
- Reset: hold Rst_n=0 for 3 edges with arbitrary inputs → Y=0, Y_valid=0, Ch_out=0, no pulses.
- Manual select (W=8, N=4): Data_in = {8'hDD,8'hCC,8'hBB,8'hAA}, Enable=1, Mode=0, Select 0→2 → Ch_out=2 after 1 edge; Y=8'hCC after 2 edges; one Switch_pulse.
- Scan wrap (DWELL=3): Mode=1 from ch=0 → Y shows AA×3, BB×3, CC×3, DD×3, then AA; Switch_pulse every 3rd cycle, including the wrap 3→0.
- Freeze: Enable=0 at cnt=1 on ch=2 for 5 cycles → Y_valid=0, Y/Ch_out constant; re-enable → ch=2 lasts 2 more cycles, then ch=3.
- Illegal select (N=3): Select=3 in manual → Sel_err one cycle, Ch_out unchanged, Y continues from old channel.
- Mode switch and reset mid-scan: SCAN→MANUAL at cnt=2 with Select=1 → Ch_out=1 next edge. Rst_n=0 during scan on ch=3 → ch=0 and Y=0 on that edge.
